// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide/modulo, sequenced by a small FSM.
module alu_multiciclo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic [3:0]   selec_alu,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         Neg,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         div_zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] N_VAL = N[N-1:0];

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [3:0]    op;
    logic [N-1:0]  opnd;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [CW-1:0] cnt;

    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [N-1:0]  sc_r;
    logic          sc_c;
    logic          sc_v;
    logic          sc_neg;
    logic          sc_dz;
    logic          multi;

    // Single-cycle datapath works straight off the inputs at the accepting edge.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        diff   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, ci};
        sc_r   = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        unique case (selec_alu)
            4'd0: begin
                sc_r = sum[N-1:0];
                sc_c = sum[N];
                sc_v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            4'd1: begin
                sc_r = diff[N-1:0];
                sc_c = ~diff[N];
                sc_v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            4'd3: begin
                sc_r  = '1;
                sc_dz = 1'b1;
            end
            4'd4: begin
                sc_r  = a;
                sc_dz = 1'b1;
            end
            4'd5: sc_r = a & b;
            4'd6: sc_r = a | b;
            4'd7: sc_r = a ^ b;
            4'd8: sc_r = (b >= N_VAL) ? '0 : (a << b);
            4'd9: sc_r = (b >= N_VAL) ? '0 : (a >> b);
            default: sc_r = '0;
        endcase
        sc_neg = (selec_alu <= 4'd9) ? sc_r[N-1] : 1'b0;
        multi  = (selec_alu == 4'd2) ||
                 (((selec_alu == 4'd3) || (selec_alu == 4'd4)) && (b != '0));
    end

    logic [N:0]   mul_sum;
    logic [N:0]   rem_sh;
    logic [N:0]   trial;
    logic         ge;
    logic [N-1:0] it_hi;
    logic [N-1:0] it_lo;
    logic [N-1:0] fin_r;

    // One iteration step: for mul {hi,lo} is the product register with the
    // multiplier in lo; for div hi is the partial remainder and lo shifts the
    // dividend out while the quotient shifts in.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        rem_sh  = {hi, lo[N-1]};
        trial   = rem_sh - {1'b0, opnd};
        ge      = ~trial[N];
        if (op == 4'd2) begin
            it_hi = mul_sum[N:1];
            it_lo = {mul_sum[0], lo[N-1:1]};
        end else begin
            it_hi = ge ? trial[N-1:0] : rem_sh[N-1:0];
            it_lo = {lo[N-2:0], ge};
        end
        fin_r = (op == 4'd4) ? it_hi : it_lo;
    end

    // Control FSM; outputs and flags are registered and updated only on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            op       <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            Neg      <= 1'b0;
            Z        <= 1'b0;
            C        <= 1'b0;
            V        <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op <= selec_alu;
                        if (multi) begin
                            opnd  <= (selec_alu == 4'd2) ? a : b;
                            lo    <= (selec_alu == 4'd2) ? b : a;
                            hi    <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= EXEC;
                        end else begin
                            result   <= sc_r;
                            Neg      <= sc_neg;
                            Z        <= (sc_r == '0);
                            C        <= sc_c;
                            V        <= sc_v;
                            div_zero <= sc_dz;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                EXEC: begin
                    hi  <= it_hi;
                    lo  <= it_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result   <= fin_r;
                        Neg      <= fin_r[N-1];
                        Z        <= (fin_r == '0);
                        C        <= 1'b0;
                        V        <= (op == 4'd2) && (it_hi != '0);
                        div_zero <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Randomised and directed bench for alu_multiciclo against an arithmetic
// reference model of the ALU operations and their latencies.
module tb_alu_multiciclo;

    localparam int N = 8;
    localparam int M = 1 << N;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic [3:0]   selec_alu;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         Neg;
    logic         Z;
    logic         C;
    logic         V;
    logic         div_zero;

    int passed = 0;
    int total  = 0;

    alu_multiciclo #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .selec_alu(selec_alu), .busy(busy), .done(done), .result(result),
        .Neg(Neg), .Z(Z), .C(C), .V(V), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {result, Neg, Z, C, V, div_zero} and start-to-done latency.
    function automatic logic [N+4:0] model(input int ua, input int ub, input int uci,
                                           input int op, output int lat);
        int r, s, sa, sb, ss;
        bit c, v, dz, inv;
        c = 0; v = 0; dz = 0; inv = 0; lat = 1; r = 0;
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        case (op)
            0: begin
                s = ua + ub + uci; r = s % M; c = (s >= M);
                ss = sa + sb + uci; v = (ss >= M/2) || (ss < -M/2);
            end
            1: begin
                s = ua - ub - uci; r = (s + 2*M) % M; c = (ua >= ub + uci);
                ss = sa - sb - uci; v = (ss >= M/2) || (ss < -M/2);
            end
            2: begin r = (ua * ub) % M; v = (ua * ub) >= M; lat = N + 1; end
            3: if (ub == 0) begin r = M - 1; dz = 1; end else begin r = ua / ub; lat = N + 1; end
            4: if (ub == 0) begin r = ua; dz = 1; end else begin r = ua % ub; lat = N + 1; end
            5: r = ua & ub;
            6: r = ua | ub;
            7: r = ua ^ ub;
            8: r = (ub >= N) ? 0 : (ua << ub) % M;
            9: r = (ub >= N) ? 0 : ua >> ub;
            default: begin r = 0; inv = 1; end
        endcase
        model = {r[N-1:0], (inv ? 1'b0 : (r >= M/2)), (r == 0), c, v, dz};
    endfunction

    function automatic logic [N+4:0] observed();
        observed = {result, Neg, Z, C, V, div_zero};
    endfunction

    // Drives one operation and samples until done (bounded); optionally pulses
    // start with different operands while the op is in progress.
    task automatic do_op(input int ia, input int ib, input int ici, input int iop,
                         input bit mid_start, output logic [N+4:0] obs,
                         output int lat, output int busy_cnt, output bit pulse_ok);
        @(negedge clk);
        a = ia[N-1:0]; b = ib[N-1:0]; ci = ici[0]; selec_alu = iop[3:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (mid_start && lat == 3) begin
                a = ~ia[N-1:0]; b = ib[N-1:0] + 8'd3; selec_alu = 4'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        obs = observed();
        @(posedge clk); #1;
        pulse_ok = !done;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; selec_alu = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, observed()} !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", {busy, done, observed()});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        int ea[7] = '{200, 127, 5, 100, 100, 0, 0};
        int eb[7] = '{100, 1, 7, 7, 0, 9, 0};
        int eop[7] = '{0, 0, 1, 4, 3, 9, 12};
        logic [N+4:0] obs, exp_v;
        int lat, elat, bc;
        bit pok;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) ea[i] = 'h80;
            exp_v = model(ea[i], eb[i], 0, eop[i], elat);
            do_op(ea[i], eb[i], 0, eop[i], 0, obs, lat, bc, pok);
            total++;
            if (obs !== exp_v) $display("[TB] FAIL directed_%0d: got %h expected %h", i, obs, exp_v);
            else passed++;
            total++;
            if (lat !== elat || !pok) $display("[TB] FAIL directed_lat_%0d: got %0d/%0d expected %0d/1", i, lat, pok, elat);
            else passed++;
        end
        do_op('h81, 1, 0, 8, 0, obs, lat, bc, pok);
        total++;
        if (obs[N+4:5] !== 8'h02) $display("[TB] FAIL shl_81: got %h expected 02", obs[N+4:5]);
        else passed++;
        do_op(100, 7, 0, 3, 0, obs, lat, bc, pok);
        total++;
        if (obs[N+4:5] !== 8'd14 || lat !== 9) $display("[TB] FAIL div_100_7: got %0d lat %0d expected 14 lat 9", obs[N+4:5], lat);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        logic [N+4:0] obs, exp_v;
        int lat, elat, bc;
        bit pok;
        exp_v = model(16, 20, 0, 2, elat);
        do_op(16, 20, 0, 2, 1, obs, lat, bc, pok);
        total++;
        if (obs !== exp_v) $display("[TB] FAIL mul_mid_start: got %h expected %h", obs, exp_v);
        else passed++;
        total++;
        if (bc !== 8 || lat !== 9) $display("[TB] FAIL mul_busy: got busy %0d lat %0d expected 8 and 9", bc, lat);
        else passed++;
    endtask

    task automatic test_random();
        logic [N+4:0] obs, exp_v;
        int lat, elat, bc, ra, rb, rc, rop;
        bit pok;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom_range(0, M - 1);
            rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1);
            if (i % 5 == 0) rb = $urandom_range(0, N + 2);
            rc = $urandom_range(0, 1);
            rop = (i % 3 == 0) ? $urandom_range(2, 4) : $urandom_range(0, 15);
            exp_v = model(ra, rb, rc, rop, elat);
            do_op(ra, rb, rc, rop, i % 2 == 1, obs, lat, bc, pok);
            total++;
            if (obs !== exp_v) $display("[TB] FAIL rand_%0d op%0d a%0d b%0d ci%0d: got %h expected %h", i, rop, ra, rb, rc, obs, exp_v);
            else passed++;
            total++;
            if (lat !== elat || bc !== elat - 1 || !pok) $display("[TB] FAIL rand_lat_%0d: got lat %0d busy %0d pulse %0d expected %0d", i, lat, bc, pok, elat);
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [N+4:0] obs, exp_v;
        int lat, elat, bc;
        bit pok;
        exp_v = model(201, 13, 0, 3, elat);
        do_op(201, 13, 0, 3, 0, obs, lat, bc, pok);
        a = 8'h11; b = 8'h22; selec_alu = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (observed() !== exp_v || done !== 1'b0) $display("[TB] FAIL hold: got %h expected %h", observed(), exp_v);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [N+4:0] exp_v;
        int elat;
        @(negedge clk);
        a = 8'd10; b = 8'd20; ci = 1'b0; selec_alu = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        exp_v = model(10, 20, 0, 0, elat);
        total++;
        if (!done || observed() !== exp_v) $display("[TB] FAIL b2b_first: got %h done %0d expected %h", observed(), done, exp_v);
        else passed++;
        a = 8'd50; b = 8'd60; selec_alu = 4'd7;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || observed() !== exp_v) $display("[TB] FAIL b2b_done_ignores_start: got %h done %0d expected %h", observed(), done, exp_v);
        else passed++;
        @(posedge clk); #1;
        start = 1'b0;
        exp_v = model(50, 60, 0, 7, elat);
        total++;
        if (!done || observed() !== exp_v) $display("[TB] FAIL b2b_second: got %h done %0d expected %h", observed(), done, exp_v);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N+4:0] obs, exp_v;
        int lat, elat, bc;
        bit pok, saw_done;
        do_op(3, 4, 0, 0, 0, obs, lat, bc, pok);
        @(negedge clk);
        a = 8'd16; b = 8'd20; selec_alu = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 0;
        repeat (3) begin @(posedge clk); #1; saw_done |= done; end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        saw_done |= done;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || saw_done)
            $display("[TB] FAIL reset_mid: got busy %0d done %0d result %h early_done %0d expected 0 0 00 0", busy, done, result, saw_done);
        else passed++;
        @(negedge clk);
        rst = 1'b1; a = 8'd200; b = 8'd100; ci = 1'b0; selec_alu = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_v = model(200, 100, 0, 0, elat);
        total++;
        if (!done || observed() !== exp_v) $display("[TB] FAIL after_reset_add: got %h done %0d expected %h", observed(), done, exp_v);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
